writeback_arbiter: RTL

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_pkg.sv | 29 ++
 rtl/writeback_arbiter_fifo.sv | 105 ++++++++++
 rtl/writeback_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared core definitions for the writeback arbiter: widths, default
// long-result queue depth, the queue entry layout and a label helper.
package writeback_arbiter_pkg;

    localparam int WB_DEPTH = 4;
    localparam int LABEL_W  = 5;
    localparam int DATA_W   = 32;

    typedef logic [LABEL_W-1:0] label_t;
    typedef logic [DATA_W-1:0]  data_t;

    typedef struct packed {
        label_t label;
        data_t  data;
        logic   live;
    } wb_entry_t;

    localparam label_t    LABEL_ZERO    = {LABEL_W{1'b0}};
    localparam data_t     DATA_ZERO     = {DATA_W{1'b0}};
    localparam wb_entry_t WB_ENTRY_ZERO = '{label: {LABEL_W{1'b0}},
                                            data:  {DATA_W{1'b0}},
                                            live:  1'b0};

    // Register x0 is hardwired, so a zero label never names a real destination.
    function automatic logic label_hit(input label_t entry_label, input label_t query_label);
        return (entry_label == query_label) && (query_label != LABEL_ZERO);
    endfunction

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Long-result queue: label, data and live bit per entry. A main-pipeline
// write to the same register kills matching entries so the stale long
// result is discarded when it reaches the head.
module wb_long_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  label_t                   push_label_i,
    input  data_t                    push_data_i,
    input  logic                     pop_i,
    input  logic                     kill_i,
    input  label_t                   kill_label_i,
    input  label_t                   rs1_label_i,
    input  label_t                   rs2_label_i,
    output label_t                   head_label_o,
    output data_t                    head_data_o,
    output logic                     head_live_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     hazard_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    wb_entry_t       entry_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_ok_s;
    logic            pop_ok_s;
    logic            hazard_s;

    assign empty_o      = (count_r == CNT_ZERO);
    assign full_o       = (count_r == CNT_FULL);
    assign count_o      = count_r;
    assign head_label_o = entry_r[rd_ptr_r].label;
    assign head_data_o  = entry_r[rd_ptr_r].data;
    assign head_live_o  = entry_r[rd_ptr_r].live;
    assign hazard_o     = hazard_s;

    // Guard the handshakes locally so a misbehaving caller cannot corrupt occupancy.
    always_comb begin
        push_ok_s = push_i & ~full_o;
        pop_ok_s  = pop_i & ~empty_o;
    end

    // Entry storage, pointers and occupancy; kill, pop and push may all act in one cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= WB_ENTRY_ZERO;
            end
        end else begin
            if (kill_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (entry_r[i].label == kill_label_i) begin
                        entry_r[i].live <= 1'b0;
                    end
                end
            end
            if (pop_ok_s) begin
                entry_r[rd_ptr_r].live <= 1'b0;
                rd_ptr_r               <= rd_ptr_r + PTR_ONE;
            end
            if (push_ok_s) begin
                entry_r[wr_ptr_r] <= '{label: push_label_i, data: push_data_i, live: 1'b1};
                wr_ptr_r          <= wr_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Scoreboard query: any live entry naming either decode source register.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_r[i].live &&
                (label_hit(entry_r[i].label, rs1_label_i) ||
                 label_hit(entry_r[i].label, rs2_label_i))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: the in-order pipeline result always wins
// the single write port; completed long (mul/div) results wait in a queue
// and drain in idle cycles. The write port is registered.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     main_valid_i,
    input  logic                     main_wb_en_i,
    input  logic [LABEL_W-1:0]       main_rd_label_i,
    input  logic [DATA_W-1:0]        main_rd_data_i,
    input  logic                     long_valid_i,
    input  logic [LABEL_W-1:0]       long_rd_label_i,
    input  logic [DATA_W-1:0]        long_rd_data_i,
    output logic                     long_ready_o,
    input  logic [LABEL_W-1:0]       rs1_label_i,
    input  logic [LABEL_W-1:0]       rs2_label_i,
    output logic                     pending_hazard_o,
    output logic                     rd_enable_o,
    output logic [LABEL_W-1:0]       rd_label_o,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    logic    main_act_s;
    logic    push_s;
    logic    pop_s;
    logic    fifo_empty_s;
    logic    fifo_full_s;
    logic    head_live_s;
    label_t  head_label_s;
    data_t   head_data_s;

    // Port arbitration: main never stalls; the queue head drains only in main-idle cycles.
    always_comb begin
        main_act_s   = main_valid_i & main_wb_en_i & (main_rd_label_i != LABEL_ZERO);
        long_ready_o = ~fifo_full_s;
        // A zero-label long result completes its handshake but is not stored.
        push_s       = long_valid_i & ~fifo_full_s & (long_rd_label_i != LABEL_ZERO);
        pop_s        = ~main_act_s & ~fifo_empty_s;
        busy_o       = ~fifo_empty_s;
    end

    wb_long_fifo #(
        .DEPTH (DEPTH)
    ) u_long_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push_s),
        .push_label_i (long_rd_label_i),
        .push_data_i  (long_rd_data_i),
        .pop_i        (pop_s),
        .kill_i       (main_act_s),
        .kill_label_i (main_rd_label_i),
        .rs1_label_i  (rs1_label_i),
        .rs2_label_i  (rs2_label_i),
        .head_label_o (head_label_s),
        .head_data_o  (head_data_s),
        .head_live_o  (head_live_s),
        .empty_o      (fifo_empty_s),
        .full_o       (fifo_full_s),
        .count_o      (count_o),
        .hazard_o     (pending_hazard_o)
    );

    // Registered write port; label/data hold their last value when nothing is written.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_enable_o <= 1'b0;
            rd_label_o  <= LABEL_ZERO;
            rd_data_o   <= DATA_ZERO;
        end else if (main_act_s) begin
            rd_enable_o <= 1'b1;
            rd_label_o  <= main_rd_label_i;
            rd_data_o   <= main_rd_data_i;
        end else if (pop_s && head_live_s) begin
            rd_enable_o <= 1'b1;
            rd_label_o  <= head_label_s;
            rd_data_o   <= head_data_s;
        end else begin
            rd_enable_o <= 1'b0;
        end
    end

endmodule
